// File: rtl/lpc_defines.sv
// Shared LPC definitions: host/peripheral state encodings, frame codes and
// SYNC codes used by both sides of the bus.
package lpc_defines;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_CYCTYPE = 4'd2,
    ST_ADDR    = 4'd3,
    ST_WDATA   = 4'd4,
    ST_TAR     = 4'd5,
    ST_SYNC    = 4'd6,
    ST_RDATA   = 4'd7,
    ST_FTAR    = 4'd8,
    ST_ABORT   = 4'd9
  } host_state_e;

  typedef enum logic [2:0] {
    PERIPH_IDLE    = 3'd0,
    PERIPH_CYCTYPE = 3'd1,
    PERIPH_ADDR    = 3'd2,
    PERIPH_WDATA   = 3'd3,
    PERIPH_TAR     = 3'd4,
    PERIPH_SYNC    = 3'd5,
    PERIPH_RDATA   = 3'd6,
    PERIPH_FTAR    = 3'd7
  } periph_state_e;

  localparam logic [3:0] START_CODE_DEF = 4'h5;
  localparam logic [3:0] CYC_IO_RD      = 4'h0;
  localparam logic [3:0] CYC_IO_WR      = 4'h2;

  localparam logic [3:0] SYNC_READY     = 4'h0;
  localparam logic [3:0] SYNC_SWAIT     = 4'h5;
  localparam logic [3:0] SYNC_LWAIT     = 4'h6;
  localparam logic [3:0] SYNC_ERR       = 4'hA;

  localparam logic [3:0] LAD_IDLE       = 4'hF;

  // Address nibbles go out MSB first: idx 0 -> addr[15:12].
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr,
                                             input logic [1:0]  idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = addr[15:12];
      2'd1:    n = addr[11:8];
      2'd2:    n = addr[7:4];
      default: n = addr[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lpc_sync_watchdog.sv
// SYNC-phase watchdog: classifies the sampled LAD nibble and runs the two
// abort timers (consecutive no-sync clocks, total clocks in SYNC).
module lpc_sync_watchdog
  import lpc_defines::*;
#(
  parameter int SYNC_TIMEOUT = 16,
  parameter int LWAIT_MAX    = 256
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       en_i,
  input  logic [3:0] lad_i,
  output logic       ready_o,
  output logic       error_o,
  output logic       timeout_o
);

  localparam int NW = $clog2(SYNC_TIMEOUT + 1);
  localparam int TW = $clog2(LWAIT_MAX + 1);
  localparam logic [NW-1:0] NS_LOAD  = NW'(SYNC_TIMEOUT - 1);
  localparam logic [TW-1:0] TOT_LOAD = TW'(LWAIT_MAX - 1);

  logic [NW-1:0] nosync_q;
  logic [TW-1:0] total_q;
  logic          is_ready;
  logic          is_err;
  logic          is_wait;

  assign is_ready  = en_i && (lad_i == SYNC_READY);
  assign is_err    = en_i && (lad_i == SYNC_ERR);
  assign is_wait   = (lad_i == SYNC_SWAIT) || (lad_i == SYNC_LWAIT);

  assign ready_o   = is_ready;
  assign error_o   = is_err;
  // A valid sync code on the terminal clock still wins over the abort.
  assign timeout_o = en_i && !is_ready && !is_err &&
                     ((!is_wait && (nosync_q == '0)) || (total_q == '0));

  // Down-counters reload outside SYNC; a wait code restarts the no-sync timer.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      nosync_q <= '0;
      total_q  <= '0;
    end else if (!en_i) begin
      nosync_q <= NS_LOAD;
      total_q  <= TOT_LOAD;
    end else begin
      if (total_q != '0) total_q <= total_q - TW'(1);
      if (is_wait) nosync_q <= NS_LOAD;
      else if (nosync_q != '0) nosync_q <= nosync_q - NW'(1);
    end
  end

endmodule

// File: rtl/lpc_host.sv
// LPC I/O-cycle host: accepts one request at a time, runs the LPC frame
// (START .. FTAR) and reports completion with read data / error status.
//
// state   | meaning
// IDLE    | waiting for a request (ready unless completing this clock)
// START   | lframe low, START code on LAD
// CYCTYPE | I/O read or write cycle type
// ADDR    | 4 address nibbles, MSB first
// WDATA   | 2 write data nibbles, low first (writes only)
// TAR     | drive F, then release LAD
// SYNC    | peripheral sync / wait codes, watched by lpc_sync_watchdog
// RDATA   | 2 read data nibbles, low first (reads only)
// FTAR    | final turnaround, LAD released; also the release clock after ABORT
// ABORT   | lframe low with LAD=F for 4 clocks
module lpc_host
  import lpc_defines::*;
#(
  parameter logic [3:0] START_CODE   = START_CODE_DEF,
  parameter int         SYNC_TIMEOUT = 16,
  parameter int         LWAIT_MAX    = 256
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        err_o,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus
);

  host_state_e state_q, state_d;
  logic [1:0]  nib_q, nib_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  shift_q, shift_d;
  logic        sync_err_q, sync_err_d;
  logic        aborted_q, aborted_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        lframe_q, lframe_d;
  logic        lad_oe_q, lad_oe_d;
  logic [3:0]  lad_out_q, lad_out_d;

  logic wd_ready;
  logic wd_error;
  logic wd_timeout;

  lpc_sync_watchdog #(
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .LWAIT_MAX    (LWAIT_MAX)
  ) u_sync_watchdog (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .en_i      (state_q == ST_SYNC),
    .lad_i     (lad_bus),
    .ready_o   (wd_ready),
    .error_o   (wd_error),
    .timeout_o (wd_timeout)
  );

  assign req_ready_o = ready_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign lframe_o    = lframe_q;
  assign lad_bus     = lad_oe_q ? lad_out_q : 4'bzzzz;

  // Next state, captured request, and the bus drive for the next state.
  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    shift_d    = shift_q;
    sync_err_d = sync_err_q;
    aborted_d  = aborted_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          wr_d       = req_wr_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          sync_err_d = 1'b0;
          aborted_d  = 1'b0;
          nib_d      = 2'd0;
          state_d    = ST_START;
        end
      end
      ST_START: state_d = ST_CYCTYPE;
      ST_CYCTYPE: begin
        nib_d   = 2'd0;
        state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (nib_q == 2'd3) begin
          nib_d   = 2'd0;
          state_d = wr_q ? ST_WDATA : ST_TAR;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      ST_WDATA: begin
        if (nib_q == 2'd1) begin
          nib_d   = 2'd0;
          state_d = ST_TAR;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      ST_TAR: begin
        if (nib_q == 2'd1) begin
          nib_d   = 2'd0;
          state_d = ST_SYNC;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      ST_SYNC: begin
        if (wd_ready || wd_error) begin
          sync_err_d = wd_error;
          nib_d      = 2'd0;
          state_d    = wr_q ? ST_FTAR : ST_RDATA;
        end else if (wd_timeout) begin
          nib_d   = 2'd0;
          state_d = ST_ABORT;
        end
      end
      ST_RDATA: begin
        if (nib_q == 2'd0) shift_d[3:0] = lad_bus;
        else               shift_d[7:4] = lad_bus;
        if (nib_q == 2'd1) begin
          nib_d   = 2'd0;
          state_d = ST_FTAR;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      ST_FTAR: begin
        if (nib_q == 2'd1) begin
          nib_d   = 2'd0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = aborted_q | sync_err_q;
          if (!aborted_q) rdata_d = shift_q;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      ST_ABORT: begin
        if (nib_q == 2'd3) begin
          // Single release clock: reuse the last FTAR slot.
          nib_d     = 2'd1;
          aborted_d = 1'b1;
          state_d   = ST_FTAR;
        end else begin
          nib_d = nib_q + 2'd1;
        end
      end
      default: begin
        nib_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    lframe_d  = 1'b1;
    lad_oe_d  = 1'b0;
    lad_out_d = LAD_IDLE;
    case (state_d)
      ST_START: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = START_CODE;
      end
      ST_CYCTYPE: begin
        lad_oe_d  = 1'b1;
        lad_out_d = wr_d ? CYC_IO_WR : CYC_IO_RD;
      end
      ST_ADDR: begin
        lad_oe_d  = 1'b1;
        lad_out_d = addr_nibble(addr_d, nib_d);
      end
      ST_WDATA: begin
        lad_oe_d  = 1'b1;
        lad_out_d = (nib_d == 2'd0) ? wdata_d[3:0] : wdata_d[7:4];
      end
      ST_TAR: begin
        lad_oe_d  = (nib_d == 2'd0);
        lad_out_d = LAD_IDLE;
      end
      ST_ABORT: begin
        lframe_d  = 1'b0;
        lad_oe_d  = 1'b1;
        lad_out_d = LAD_IDLE;
      end
      default: ;
    endcase

    // Not ready on the completion clock, so a held request lands one later.
    ready_d = (state_d == ST_IDLE) && !done_d;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= ST_IDLE;
      nib_q      <= 2'd0;
      wr_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      shift_q    <= 8'h00;
      sync_err_q <= 1'b0;
      aborted_q  <= 1'b0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      lframe_q   <= 1'b1;
      lad_oe_q   <= 1'b0;
      lad_out_q  <= LAD_IDLE;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      shift_q    <= shift_d;
      sync_err_q <= sync_err_d;
      aborted_q  <= aborted_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      lframe_q   <= lframe_d;
      lad_oe_q   <= lad_oe_d;
      lad_out_q  <= lad_out_d;
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: a scheduled LPC responder on the bus, a trace of
// lframe/LAD per clock after acceptance, and a scoreboard of completions.
module tb_lpc_host;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        done_o;
  logic [7:0]  rdata_o;
  logic        err_o;
  logic        lframe_o;
  wire  [3:0]  lad_bus;

  logic        tb_oe;
  logic [3:0]  tb_val;

  assign lad_bus = tb_oe ? tb_val : 4'bzzzz;
  pulldown pd_lad (lad_bus);

  always #5 clk_i = ~clk_i;

  lpc_host dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_wr_i    (req_wr_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .lframe_o    (lframe_o),
    .lad_bus     (lad_bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;
  exp_t       exp_q[$];
  logic [7:0] model_rdata;

  // Responder schedule, relative to the START clock at rsp_base.
  int         rsp_mode;     // 0 silent, 1 respond, 2 float high (no hit)
  int         rsp_base;
  int         rsp_sync_at;
  int         rsp_waits;
  logic [3:0] rsp_code;
  logic [7:0] rsp_data;
  logic       rsp_rd;

  logic [3:0] tr_lad[0:79];
  logic       tr_lf[0:79];
  int         got_lat;
  logic [7:0] got_rdata;
  logic       got_err;

  task automatic rsp_drive(input int i);
    int r = i - rsp_base;
    int s = rsp_sync_at + rsp_waits;
    tb_oe  = 1'b0;
    tb_val = 4'h0;
    if (rsp_mode == 1) begin
      if (r >= rsp_sync_at && r < s) begin
        tb_oe = 1'b1; tb_val = 4'h6;
      end else if (r == s) begin
        tb_oe = 1'b1; tb_val = rsp_code;
      end else if (rsp_rd && r == s + 1) begin
        tb_oe = 1'b1; tb_val = rsp_data[3:0];
      end else if (rsp_rd && r == s + 2) begin
        tb_oe = 1'b1; tb_val = rsp_data[7:4];
      end
    end else if (rsp_mode == 2) begin
      if (r >= rsp_sync_at && r < rsp_sync_at + 16) begin
        tb_oe = 1'b1; tb_val = 4'hF;
      end
    end
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready_o === 1'b1) begin
        ok = 1;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL ready_timeout: req_ready_o=%b required 1", req_ready_o);
    end
  endtask

  // Issue one request, then trace the bus each clock until done_o.
  task automatic run_txn(input logic wr, input logic [15:0] addr,
                         input logic [7:0] wd, input int max_cyc);
    wait_ready();
    req_valid_i = 1'b1;
    req_wr_i    = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    got_lat = -1;
    for (int i = 0; i < max_cyc && i < 80; i++) begin
      rsp_drive(i);
      #1;
      tr_lad[i] = lad_bus;
      tr_lf[i]  = lframe_o;
      if (done_o === 1'b1) begin
        got_lat   = i;
        got_rdata = rdata_o;
        got_err   = err_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    tb_oe = 1'b0;
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = 16'h0; req_wdata_i = 8'h0;
    tb_oe = 1'b0; tb_val = 4'h0; rsp_mode = 0; rsp_base = 0;
    model_rdata = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    tests++; if (lframe_o !== 1'b1) begin fails++; $display("FAIL rst_lframe: got %b required 1", lframe_o); end
    tests++; if (lad_bus !== 4'h0) begin fails++; $display("FAIL rst_lad_released: got %h required 0 (pulldown)", lad_bus); end
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b required 0", req_ready_o); end
    tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b required 0", err_o); end
    tests++; if (rdata_o !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h required 00", rdata_o); end
    #2 nrst_i = 1'b1;
    @(posedge clk_i); #1;
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b required 1", req_ready_o); end
  endtask

  task automatic test_write();
    logic [3:0] seq[0:9];
    exp_t e;
    seq = '{4'h5, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h5, 4'hA, 4'hF, 4'h0};
    rsp_mode = 1; rsp_base = 0; rsp_sync_at = 10; rsp_waits = 0;
    rsp_code = 4'h0; rsp_rd = 1'b0; rsp_data = 8'h00;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0, lat: 13});
    run_txn(1'b1, 16'h0080, 8'hA5, 80);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (tr_lad[i] !== seq[i]) begin
        fails++; $display("FAIL wr_lad[%0d]: got %h required %h", i, tr_lad[i], seq[i]);
      end
    end
    tests++;
    if ({tr_lad[7], tr_lad[6]} !== 8'hA5) begin
      fails++; $display("FAIL wr_periph_data: got %h required a5", {tr_lad[7], tr_lad[6]});
    end
    tests++;
    if (tr_lf[0] !== 1'b0 || tr_lf[1] !== 1'b1) begin
      fails++; $display("FAIL wr_lframe_start: got %b%b required 01", tr_lf[0], tr_lf[1]);
    end
    e = exp_q.pop_front();
    tests++; if (got_lat !== e.lat) begin fails++; $display("FAIL wr_latency: got %0d required %0d", got_lat, e.lat); end
    tests++; if (got_err !== e.err) begin fails++; $display("FAIL wr_err: got %b required %b", got_err, e.err); end
    tests++; if (got_rdata !== e.rdata) begin fails++; $display("FAIL wr_rdata_kept: got %h required %h", got_rdata, e.rdata); end
  endtask

  task automatic test_read();
    logic [3:0] seq[0:7];
    exp_t e;
    seq = '{4'h5, 4'h0, 4'h0, 4'hC, 4'hF, 4'h8, 4'hF, 4'h0};
    rsp_mode = 1; rsp_base = 0; rsp_sync_at = 8; rsp_waits = 0;
    rsp_code = 4'h0; rsp_rd = 1'b1; rsp_data = 8'h3C;
    model_rdata = 8'h3C;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0, lat: 13});
    run_txn(1'b0, 16'h0CF8, 8'h00, 80);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (tr_lad[i] !== seq[i]) begin
        fails++; $display("FAIL rd_lad[%0d]: got %h required %h", i, tr_lad[i], seq[i]);
      end
    end
    e = exp_q.pop_front();
    tests++; if (got_lat !== e.lat) begin fails++; $display("FAIL rd_latency: got %0d required %0d", got_lat, e.lat); end
    tests++; if (got_rdata !== e.rdata) begin fails++; $display("FAIL rd_rdata: got %h required %h", got_rdata, e.rdata); end
    tests++; if (got_err !== e.err) begin fails++; $display("FAIL rd_err: got %b required %b", got_err, e.err); end
  endtask

  task automatic test_wait_read();
    exp_t e;
    rsp_mode = 1; rsp_base = 0; rsp_sync_at = 8; rsp_waits = 40;
    rsp_code = 4'h0; rsp_rd = 1'b1; rsp_data = 8'h11;
    model_rdata = 8'h11;
    exp_q.push_back('{rdata: model_rdata, err: 1'b0, lat: 53});
    run_txn(1'b0, 16'h0060, 8'h00, 80);
    e = exp_q.pop_front();
    tests++; if (got_lat !== e.lat) begin fails++; $display("FAIL wait_latency: got %0d required %0d", got_lat, e.lat); end
    tests++; if (got_rdata !== e.rdata) begin fails++; $display("FAIL wait_rdata: got %h required %h", got_rdata, e.rdata); end
    tests++; if (got_err !== e.err) begin fails++; $display("FAIL wait_err: got %b required %b", got_err, e.err); end
  endtask

  task automatic test_abort();
    exp_t e;
    int lows;
    int lows_window;
    rsp_mode = 2; rsp_base = 0; rsp_sync_at = 10; rsp_waits = 0;
    exp_q.push_back('{rdata: model_rdata, err: 1'b1, lat: 31});
    run_txn(1'b1, 16'h0070, 8'h42, 80);
    lows = 0; lows_window = 0;
    for (int j = 1; j < 80 && (got_lat < 0 || j <= got_lat); j++) begin
      if (tr_lf[j] === 1'b0) begin
        lows++;
        if (j >= 26 && j <= 29) lows_window++;
      end
    end
    tests++; if (lows !== 4) begin fails++; $display("FAIL abort_lframe_count: got %0d required 4", lows); end
    tests++; if (lows_window !== 4) begin fails++; $display("FAIL abort_lframe_place: got %0d lows in 26..29 required 4", lows_window); end
    tests++; if (tr_lad[27] !== 4'hF) begin fails++; $display("FAIL abort_lad: got %h required f", tr_lad[27]); end
    tests++;
    if (tr_lf[30] !== 1'b1 || tr_lad[30] !== 4'h0) begin
      fails++; $display("FAIL abort_release: got lframe=%b lad=%h required 1/0", tr_lf[30], tr_lad[30]);
    end
    e = exp_q.pop_front();
    tests++; if (got_lat !== e.lat) begin fails++; $display("FAIL abort_latency: got %0d required %0d", got_lat, e.lat); end
    tests++; if (got_err !== e.err) begin fails++; $display("FAIL abort_err: got %b required %b", got_err, e.err); end
    tests++; if (got_rdata !== e.rdata) begin fails++; $display("FAIL abort_rdata_kept: got %h required %h", got_rdata, e.rdata); end
  endtask

  task automatic test_sync_err_reset();
    exp_t e;
    int dones;
    rsp_mode = 1; rsp_base = 0; rsp_sync_at = 8; rsp_waits = 0;
    rsp_code = 4'hA; rsp_rd = 1'b1; rsp_data = 8'hFF;
    model_rdata = 8'hFF;
    exp_q.push_back('{rdata: model_rdata, err: 1'b1, lat: 13});
    run_txn(1'b0, 16'h0040, 8'h00, 80);
    e = exp_q.pop_front();
    tests++; if (got_lat !== e.lat) begin fails++; $display("FAIL serr_latency: got %0d required %0d", got_lat, e.lat); end
    tests++; if (got_rdata !== e.rdata) begin fails++; $display("FAIL serr_rdata: got %h required %h", got_rdata, e.rdata); end
    tests++; if (got_err !== e.err) begin fails++; $display("FAIL serr_err: got %b required %b", got_err, e.err); end

    rsp_mode = 0;
    wait_ready();
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 16'h1234;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    tests++;
    if (lad_bus !== 4'h2 || lframe_o !== 1'b1) begin
      fails++; $display("FAIL mid_addr_drive: got lad=%h lframe=%b required 2/1", lad_bus, lframe_o);
    end
    nrst_i = 1'b0;
    model_rdata = 8'h00;
    #1;
    tests++; if (lframe_o !== 1'b1) begin fails++; $display("FAIL mid_rst_lframe: got %b required 1", lframe_o); end
    tests++; if (lad_bus !== 4'h0) begin fails++; $display("FAIL mid_rst_lad: got %h required 0 (released)", lad_bus); end
    tests++; if (req_ready_o !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b required 0", req_ready_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL mid_rst_err: got %b required 0", err_o); end
    tests++; if (rdata_o !== model_rdata) begin fails++; $display("FAIL mid_rst_rdata: got %h required %h", rdata_o, model_rdata); end
    @(posedge clk_i); #1;
    nrst_i = 1'b1;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk_i); #1;
      if (done_o === 1'b1) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL mid_rst_no_done: got %0d pulses required 0", dones); end
    tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL mid_rst_ready_after: got %b required 1", req_ready_o); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   start2;
    int   ndone;
    int   done1;
    bit   drop;
    rsp_mode = 1; rsp_base = 0; rsp_sync_at = 8; rsp_waits = 0;
    rsp_code = 4'h0; rsp_rd = 1'b1; rsp_data = 8'h5A;
    exp_q.push_back('{rdata: 8'h5A, err: 1'b0, lat: 13});
    exp_q.push_back('{rdata: 8'hC3, err: 1'b0, lat: 13});
    start2 = -1; ndone = 0; done1 = -1; drop = 0;
    wait_ready();
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 16'h0010;
    @(posedge clk_i); #1;
    for (int i = 0; i < 45 && ndone < 2; i++) begin
      if (drop) req_valid_i = 1'b0;
      rsp_drive(i);
      #1;
      tr_lf[i] = lframe_o;
      if (i > 0 && lframe_o === 1'b0 && start2 < 0) begin
        start2   = i;
        rsp_base = i;
        rsp_data = 8'hC3;
      end
      if (start2 >= 0 && req_valid_i && req_ready_o === 1'b1) drop = 1;
      if (done_o === 1'b1) begin
        e = exp_q.pop_front();
        tests++;
        if ((ndone == 0 ? i : i - start2) !== e.lat) begin
          fails++; $display("FAIL b2b_latency%0d: got %0d required %0d", ndone, (ndone == 0 ? i : i - start2), e.lat);
        end
        tests++;
        if (rdata_o !== e.rdata || err_o !== e.err) begin
          fails++; $display("FAIL b2b_result%0d: got %h/%b required %h/%b", ndone, rdata_o, err_o, e.rdata, e.err);
        end
        if (ndone == 0) done1 = i;
        ndone++;
      end
      @(posedge clk_i); #1;
    end
    tb_oe = 1'b0;
    req_valid_i = 1'b0;
    tests++; if (ndone !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d required 2", ndone); end
    tests++;
    if (start2 - done1 !== 2) begin
      fails++; $display("FAIL b2b_start_gap: got %0d clocks required 2", start2 - done1);
    end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL b2b_scoreboard_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_read();
    test_abort();
    test_sync_err_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 SHALL have parameter START_CODE, default 4'h5, START nibble driven with lframe low.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 16, the number of clocks in SYNC with no valid sync code before abort.
REQ-003 SHALL have parameter LWAIT_MAX, default 256, the number of clocks in SYNC with any wait code before abort.
REQ-004 SHALL have port clk_i, input, 1, LPC clock.
REQ-005 SHALL have port nrst_i, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have ports for the request side:
- req_valid_i, input, 1, request present.
- req_ready_o, output, 1, host idle and accepting.
- req_wr_i, input, 1, 1=I/O write, 0=I/O read.
- req_addr_i, input, 16, I/O address.
- req_wdata_i, input, 8, write data.
REQ-007 SHALL have ports for the response side:
- done_o, output, 1, one-clock completion pulse.
- rdata_o, output, 8, read data, valid with done_o.
- err_o, output, 1, valid with done_o: sync error or abort.
REQ-008 SHALL have ports for the LPC side:
- lframe_o, output, 1, LPC frame, active low.
- lad_bus, inout, 4, LPC data bus, tristated when the host is not driving.

Function
REQ-009 SHALL capture req_wr_i/req_addr_i/req_wdata_i on the clock where req_valid_i and req_ready_o are both high; req_ready_o SHALL be high only in IDLE.
REQ-010 SHALL implement states IDLE, START, CYCTYPE, ADDR, WDATA, TAR, SYNC, RDATA, FTAR, ABORT; a 2-bit nibble counter SHALL index ADDR (0..3), WDATA, TAR, RDATA and FTAR (0..1), and ABORT (0..3).
REQ-011 SHALL follow the acceptance clock with START for 1 clock: lframe_o=0, lad=START_CODE.
REQ-012 SHALL follow START with CYCTYPE for 1 clock: lframe_o=1, lad=4'h0 for read or 4'h2 for write.
REQ-013 SHALL drive ADDR for 4 clocks as addr[15:12], [11:8], [7:4], [3:0] (MSB nibble first).
REQ-014 SHALL, for writes only, drive WDATA for 2 clocks as wdata[3:0] then wdata[7:4].
REQ-015 SHALL drive TAR for 2 clocks: clock 1 lad=4'hF; clock 2 lad tristated.
REQ-016 SHALL keep lad tristated in SYNC and sample lad every clock:
- 4'h0 ends SYNC, err=0.
- 4'hA ends SYNC, err=1.
- 4'h5/4'h6 are wait codes; stay in SYNC.
- Any other value (incl. 4'hF) counts toward SYNC_TIMEOUT.
REQ-017 SHALL count consecutive no-sync clocks toward SYNC_TIMEOUT and reset that count on any wait code; total clocks in SYNC SHALL count toward LWAIT_MAX.
REQ-018 SHALL go from SYNC to RDATA for reads, sampling 2 clocks into rdata_o[3:0] then rdata_o[7:4]; writes SHALL go directly to FTAR.
REQ-019 SHALL keep lad tristated for the 2 FTAR clocks, then return to IDLE with done_o=1 for exactly that one clock.
REQ-020 SHALL enter ABORT when either SYNC limit is reached:
- lframe_o=0 and lad=4'hF for 4 clocks.
- Then lframe_o=1 and lad tristated for 1 clock.
- Then IDLE with done_o=1, err_o=1, and rdata_o unchanged.
REQ-021 SHALL give a minimum latency, acceptance to done_o, of 13 clocks for both read and write (no wait states).
REQ-022 SHALL hold lframe_o=1 in every state except START and ABORT.
REQ-023 SHALL drive lad_bus only in START, CYCTYPE, ADDR, WDATA, TAR clock 1 and ABORT.
REQ-024 SHALL ignore req_valid_i while not in IDLE; a request held high at done_o SHALL be accepted on the following clock, so the next START is 2 clocks after done_o.
REQ-025 SHALL keep rdata_o and err_o stable until the next done_o.

Reset
REQ-026 SHALL, while nrst_i=0 (asynchronously, including mid-cycle), force:
- state=IDLE; lframe_o=1; lad_bus tristated.
- req_ready_o=0 while nrst_i=0, then 1 after release.
- done_o=0, err_o=0, rdata_o=8'h00, all counters 0.
REQ-027 SHALL NOT issue done_o for a cycle interrupted by reset.

Structure
REQ-028 SHALL take host state encodings, START/CYCTYPE codes and SYNC codes (READY 0, SWAIT 5, LWAIT 6, ERR A) from the shared lpc_defines package alongside the existing peripheral codes.
REQ-029 SHALL place the SYNC_TIMEOUT/LWAIT_MAX counters in one sub-module, lpc_sync_watchdog (inputs: enable, lad sample; outputs: ready, error, timeout).

Verification
REQ-030 Write addr 16'h0080, data 8'hA5, against an lpc_periph instance with addr_hit_i=1 -> lad sequence 5,2,0,0,8,0,5,A,F,Z; done_o at clock 13; err_o=0; peripheral lpc_data_in_o=8'hA5.
REQ-031 Read addr 16'h0CF8, peripheral din_i=8'h3C -> host drives 5,0,0,C,F,8,F; done_o at clock 13; rdata_o=8'h3C; err_o=0.
REQ-032 Read with responder driving 4'h6 for 40 clocks then 4'h0, data 8'h11 -> no abort; done_o at clock 53; rdata_o=8'h11.
REQ-033 Write with addr_hit_i=0 (bus floats/pulls to F) -> ABORT after 16 SYNC clocks; lframe_o low exactly 4 clocks; done_o with err_o=1.
REQ-034 SYNC 4'hA on a read, data 8'hFF -> rdata_o=8'hFF, err_o=1; then nrst_i pulsed low mid-ADDR on the next request -> immediate lframe_o=1, lad tristated, no done_o.
